exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 44 ++++
 rtl/exec_mul.sv | 59 +++++
 rtl/exec_stage.sv | 191 +++++++++++++++++++
 tb/tb_exec_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: main-decoder op classes,
// funct3/funct7 codes, the ALU operation enum and the stage FSM states.
package exec_pkg;

  // Main-decoder op classes carried on aluop.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // also selects branch compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // funct3 codes for ALU operations.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 codes for branch compares.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 bit that selects SUB/SRA, and the full multiply encoding.
  localparam int         F7_ALT_BIT = 5;
  localparam logic [6:0] F7_MUL     = 7'b0000001;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// start loads the operands; done is high during the cycle in which the
// final partial product is available on result, so the consumer can
// register it on the same edge that retires the last iteration.
module exec_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;

  // Final iteration is the one whose count is XLEN-1.
  assign done   = busy && (cnt == CW'(XLEN - 1));
  assign result = acc + (mplier[0] ? mcand : '0);

  // Shift-add iteration: accumulate, shift multiplicand left, multiplier right.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset along with control so an abandoned
    // multiply can never leak a partial product into a later operation.
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here samples the pre-edge values of the others.
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand select, ALU, branch compare and branch target,
// behind a valid/ready handshake with registered outputs.
// Optional feature macro EXEC_MUL_EN adds an iterative multiplier (exec_mul)
// for aluop=10, f3=000, f7=0000001; without it that encoding is plain ADD.
module exec_stage
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic [XLEN-1:0] readdata1,
  input  logic [XLEN-1:0] readdata2,
  input  logic [XLEN-1:0] immgen,
  input  logic            alusrc,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_output,
  output logic            zero_flag,
  output logic            branch_taken,
  output logic [XLEN-1:0] pc_branch
);

  localparam int SHW = $clog2(XLEN);

  state_e          state;
  alu_op_e         op;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] result;
  logic [SHW-1:0]  shamt;
  logic            br_cond;
  logic            accept;
  logic            pop;

  assign opb   = alusrc ? immgen : readdata2;
  assign shamt = opb[SHW-1:0];
  assign pop   = out_valid && out_ready;
  // A DONE stage whose result is being popped is as free to accept as IDLE;
  // only an in-flight multiply blocks new work.
  assign in_ready = (state != MUL) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef EXEC_MUL_EN
  logic            is_mul;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_result;
  logic            unused_mul_busy;

  assign is_mul          = (op == OP_MUL);
  assign unused_mul_busy = mul_busy;

  exec_mul #(
    .XLEN (XLEN)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_mul),
    .a      (readdata1),
    .b      (opb),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );
`else
  logic unused_f7;
  assign unused_f7 = ^{f7[6], f7[4:0]};
`endif

  // Decode aluop/f3/f7 into a single ALU operation.
  always_comb begin
    // NOTE: each always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    op = OP_ADD;
    if (aluop == ALUOP_SUB) begin
      op = OP_SUB;
    end else if (aluop == ALUOP_RTYPE || aluop == ALUOP_ITYPE) begin
      case (f3)
        F3_ADD:  op = (aluop == ALUOP_RTYPE && f7[F7_ALT_BIT]) ? OP_SUB : OP_ADD;
        F3_SLL:  op = OP_SLL;
        F3_SLT:  op = OP_SLT;
        F3_SLTU: op = OP_SLTU;
        F3_XOR:  op = OP_XOR;
        F3_SR:   op = f7[F7_ALT_BIT] ? OP_SRA : OP_SRL;
        F3_OR:   op = OP_OR;
        F3_AND:  op = OP_AND;
        default: op = OP_ADD;
      endcase
`ifdef EXEC_MUL_EN
      if (aluop == ALUOP_RTYPE && f3 == F3_ADD && f7 == F7_MUL) begin
        op = OP_MUL;
      end
`endif
    end
  end

  // Single-cycle ALU; multiply results come from exec_mul instead.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = readdata1 + opb;
      OP_SUB:  result = readdata1 - opb;
      OP_SLL:  result = readdata1 << shamt;
      OP_SLT:  result = XLEN'($signed(readdata1) < $signed(opb));
      OP_SLTU: result = XLEN'(readdata1 < opb);
      OP_XOR:  result = readdata1 ^ opb;
      OP_SRL:  result = readdata1 >> shamt;
      OP_SRA:  result = $unsigned($signed(readdata1) >>> shamt);
      OP_OR:   result = readdata1 | opb;
      OP_AND:  result = readdata1 & opb;
      default: result = '0;
    endcase
  end

  // Branch condition, only meaningful for the SUB/branch op class.
  always_comb begin
    br_cond = 1'b0;
    if (aluop == ALUOP_SUB) begin
      case (f3)
        F3_BEQ:  br_cond = (readdata1 == opb);
        F3_BNE:  br_cond = (readdata1 != opb);
        F3_BLT:  br_cond = ($signed(readdata1) <  $signed(opb));
        F3_BGE:  br_cond = ($signed(readdata1) >= $signed(opb));
        F3_BLTU: br_cond = (readdata1 <  opb);
        F3_BGEU: br_cond = (readdata1 >= opb);
        default: br_cond = 1'b0;
      endcase
    end
  end

  // Stage FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      alu_output   <= '0;
      zero_flag    <= 1'b1;
      branch_taken <= 1'b0;
      pc_branch    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            pc_branch    <= pc + immgen;
            branch_taken <= br_cond;
`ifdef EXEC_MUL_EN
            if (is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
            end else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              alu_output <= result;
              zero_flag  <= (result == '0);
            end
`else
            state      <= DONE;
            out_valid  <= 1'b1;
            alu_output <= result;
            zero_flag  <= (result == '0);
`endif
          end else if (pop) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef EXEC_MUL_EN
        MUL: begin
          if (mul_done) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            alu_output <= mul_result;
            zero_flag  <= (mul_result == '0);
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage (XLEN=32): reset values, a directed
// vector table, backpressure, multiply latency, mid-operation reset, and
// randomized operations against a behavioural reference model.
module tb_exec_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      aluop;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] readdata1;
  logic [XLEN-1:0] readdata2;
  logic [XLEN-1:0] immgen;
  logic            alusrc;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_output;
  logic            zero_flag;
  logic            branch_taken;
  logic [XLEN-1:0] pc_branch;

  exec_stage #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .aluop        (aluop),
    .f3           (f3),
    .f7           (f7),
    .readdata1    (readdata1),
    .readdata2    (readdata2),
    .immgen       (immgen),
    .alusrc       (alusrc),
    .pc           (pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_output   (alu_output),
    .zero_flag    (zero_flag),
    .branch_taken (branch_taken),
    .pc_branch    (pc_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        alusrc;
    logic [31:0] pc;
    logic [31:0] exp_alu;
    logic        exp_br;
    logic [31:0] exp_pcb;
  } vec_t;

  int passed = 0;
  int total  = 0;

`ifdef EXEC_MUL_EN
  localparam int MUL_LAT = XLEN + 1;
  localparam logic [31:0] MUL_EXP = 32'h0002_0001;
`else
  localparam int MUL_LAT = 1;
  localparam logic [31:0] MUL_EXP = 32'h0002_0002;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    aluop     = v.aluop;
    f3        = v.f3;
    f7        = v.f7;
    readdata1 = v.rd1;
    readdata2 = v.rd2;
    immgen    = v.imm;
    alusrc    = v.alusrc;
    pc        = v.pc;
  endtask

  // Issue one op, wait (bounded) for its result, capture it, then pop it.
  // lat counts clock edges from the accepting edge (=1) to the edge that
  // raised out_valid.
  task automatic run_op(input vec_t v, output int lat, output logic [31:0] alu,
                        output logic z, output logic br, output logic [31:0] pcb);
    int wait_cyc = 0;
    lat = 0; alu = '0; z = 1'b0; br = 1'b0; pcb = '0;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (!in_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    alu = alu_output;
    z   = zero_flag;
    br  = branch_taken;
    pcb = pc_branch;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Reference model straight from the operation rules.
  function automatic void model(input vec_t v, output logic [31:0] res,
                                output logic br, output logic [31:0] pcb, output int lat);
    logic [31:0] a, b;
    longint      sa, sb;
    int          sh;
    logic [63:0] prod;
    a   = v.rd1;
    b   = v.alusrc ? v.imm : v.rd2;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b % 32);
    lat = 1;
    br  = 1'b0;
    pcb = v.pc + v.imm;
    res = a + b;
    if (v.aluop == 2'b01) begin
      res = a - b;
      case (v.f3)
        3'd0: br = (a == b);
        3'd1: br = (a != b);
        3'd4: br = (sa < sb);
        3'd5: br = (sa >= sb);
        3'd6: br = (a < b);
        3'd7: br = (a >= b);
        default: br = 1'b0;
      endcase
    end else if (v.aluop[1]) begin
      case (v.f3)
        3'd0: res = (v.aluop == 2'b10 && v.f7[5]) ? a - b : a + b;
        3'd1: res = 32'(64'(a) * (64'd1 << sh));
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = v.f7[5] ? 32'(sa >>> sh) : 32'(64'(a) / (64'd1 << sh));
        3'd6: res = a | b;
        default: res = a & b;
      endcase
`ifdef EXEC_MUL_EN
      if (v.aluop == 2'b10 && v.f3 == 3'd0 && v.f7 == 7'h01) begin
        prod = 64'(a) * 64'(b);
        res  = prod[31:0];
        lat  = XLEN + 1;
      end
`endif
    end
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[18];
    vec_t        v;
    int          lat, exp_lat, seen, mr_wait;
    logic [31:0] alu, exp_alu, exp_pcb, pcb;
    logic        z, br, exp_br;

    //         aluop  f3    f7     rd1           rd2           imm           src   pc            exp_alu       br    exp_pcb
    tbl[0]  = '{2'd2, 3'd0, 7'h20, 32'd5,        32'd7,        32'd0,        1'b0, 32'h0,        32'hFFFFFFFE, 1'b0, 32'h0};
    tbl[1]  = '{2'd1, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 1'b0, 32'h100,      32'hFFFFFFFE, 1'b1, 32'hF0};
    tbl[2]  = '{2'd3, 3'd1, 7'h00, 32'd1,        32'd0,        32'd33,       1'b1, 32'h0,        32'd2,        1'b0, 32'h21};
    tbl[3]  = '{2'd3, 3'd0, 7'h20, 32'd10,       32'd0,        32'd3,        1'b1, 32'h0,        32'd13,       1'b0, 32'h3};
    tbl[4]  = '{2'd2, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0,        1'b0, 32'h1000,     32'hF8000000, 1'b0, 32'h1000};
    tbl[5]  = '{2'd3, 3'd5, 7'h20, 32'hFFFFFF00, 32'd0,        32'd8,        1'b1, 32'h0,        32'hFFFFFFFF, 1'b0, 32'h8};
    tbl[6]  = '{2'd2, 3'd5, 7'h00, 32'h80000000, 32'd31,       32'd0,        1'b0, 32'h0,        32'd1,        1'b0, 32'h0};
    tbl[7]  = '{2'd2, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 32'h0,        32'd1,        1'b0, 32'h0};
    tbl[8]  = '{2'd2, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 32'h0,        32'd0,        1'b0, 32'h0};
    tbl[9]  = '{2'd1, 3'd7, 7'h00, 32'd5,        32'd5,        32'h10,       1'b0, 32'h200,      32'd0,        1'b1, 32'h210};
    tbl[10] = '{2'd1, 3'd1, 7'h00, 32'd5,        32'd5,        32'd0,        1'b0, 32'h0,        32'd0,        1'b0, 32'h0};
    tbl[11] = '{2'd1, 3'd2, 7'h00, 32'd1,        32'd3,        32'd0,        1'b0, 32'h0,        32'hFFFFFFFE, 1'b0, 32'h0};
    tbl[12] = '{2'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b1, 32'hFFFFFFF0, 32'd0,        1'b0, 32'hFFFFFFF1};
    tbl[13] = '{2'd1, 3'd4, 7'h00, 32'd3,        32'd0,        32'd5,        1'b1, 32'h40,       32'hFFFFFFFE, 1'b1, 32'h45};
    tbl[14] = '{2'd2, 3'd7, 7'h00, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 32'h0,        32'hF000,     1'b0, 32'h0};
    tbl[15] = '{2'd3, 3'd6, 7'h00, 32'hF0F0,     32'd0,        32'hFF00,     1'b1, 32'h0,        32'hFFF0,     1'b0, 32'hFF00};
    tbl[16] = '{2'd1, 3'd5, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 32'h0,        32'd2,        1'b1, 32'h0};
    tbl[17] = '{2'd2, 3'd1, 7'h00, 32'd3,        32'd36,       32'd0,        1'b0, 32'h0,        32'h30,       1'b0, 32'h0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_alu_output", 64'(alu_output), 64'd0);
    check("reset_zero_flag", 64'(zero_flag), 64'd1);
    check("reset_branch_taken", 64'(branch_taken), 64'd0);
    check("reset_pc_branch", 64'(pc_branch), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 64'(in_ready), 64'd1);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i], lat, alu, z, br, pcb);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
      check($sformatf("vec%0d_alu_output", i), 64'(alu), 64'(tbl[i].exp_alu));
      check($sformatf("vec%0d_zero_flag", i), 64'(z), 64'(tbl[i].exp_alu == 32'd0));
      check($sformatf("vec%0d_branch_taken", i), 64'(br), 64'(tbl[i].exp_br));
      check($sformatf("vec%0d_pc_branch", i), 64'(pcb), 64'(tbl[i].exp_pcb));
    end
    check("valid_dropped_after_pop", 64'(out_valid), 64'd0);

    // Backpressure: result held for 3 cycles, then pop + accept on one edge.
    @(negedge clk);
    v = '{2'd0, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0};
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_first_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_alu_output", c), 64'(alu_output), 64'd30);
      check($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    v = '{2'd2, 3'd4, 7'h00, 32'hFF, 32'h0F, 32'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0};
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_on_pop", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_new_valid", 64'(out_valid), 64'd1);
    check("bp_new_alu_output", 64'(alu_output), 64'hF0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_valid_dropped", 64'(out_valid), 64'd0);

    // Multiply encoding: iterative product with the feature, ADD without it.
    v = '{2'd2, 3'd0, 7'h01, 32'h10001, 32'h10001, 32'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0};
    run_op(v, lat, alu, z, br, pcb);
    check("mul_latency", 64'(lat), 64'(MUL_LAT));
    check("mul_alu_output", 64'(alu), 64'(MUL_EXP));

    // Reset in the middle of an operation: nothing may be emitted afterwards.
`ifdef EXEC_MUL_EN
    v = '{2'd2, 3'd0, 7'h01, 32'd3, 32'd5, 32'd0, 1'b0, 32'h40, 32'd0, 1'b0, 32'h0};
    mr_wait = 10;
`else
    v = '{2'd0, 3'd0, 7'h00, 32'd7, 32'd1, 32'd0, 1'b0, 32'h40, 32'd0, 1'b0, 32'h0};
    mr_wait = 2;
`endif
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (mr_wait) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_zero_flag", 64'(zero_flag), 64'd1);
    check("midreset_alu_output", 64'(alu_output), 64'd0);
    check("midreset_pc_branch", 64'(pc_branch), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midreset_no_stray_result", 64'(seen), 64'd0);
    v = '{2'd0, 3'd0, 7'h00, 32'd2, 32'd3, 32'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0};
    run_op(v, lat, alu, z, br, pcb);
    check("post_reset_add_latency", 64'(lat), 64'd1);
    check("post_reset_add_result", 64'(alu), 64'd5);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      v.aluop = 2'($urandom_range(0, 3));
      v.f3    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       v.f7 = 7'h00;
        1:       v.f7 = 7'h20;
        2:       v.f7 = 7'h01;
        default: v.f7 = 7'($urandom);
      endcase
      v.rd1    = rnd_word();
      v.rd2    = rnd_word();
      v.imm    = rnd_word();
      v.alusrc = 1'($urandom_range(0, 1));
      v.pc     = 32'($urandom);
      model(v, exp_alu, exp_br, exp_pcb, exp_lat);
      run_op(v, lat, alu, z, br, pcb);
      check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(exp_lat));
      check($sformatf("rnd%0d_alu_output", n), 64'(alu), 64'(exp_alu));
      check($sformatf("rnd%0d_zero_flag", n), 64'(z), 64'(exp_alu == 32'd0));
      check($sformatf("rnd%0d_branch_taken", n), 64'(br), 64'(exp_br));
      check($sformatf("rnd%0d_pc_branch", n), 64'(pcb), 64'(exp_pcb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
